// File: rtl/icache_pkg.sv
// ----------------------------------------------------------------------------
// icache_pkg: geometry, address-field slices and FSM encoding for instr_cache.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package icache_pkg;

  localparam int LINES    = 8;
  localparam int WORD_W   = 32;
  localparam int BLOCK_W  = 128;
  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int MADDR_W  = TAG_W + INDEX_W;

  localparam int OFF_LSB  = 2;
  localparam int OFF_MSB  = 3;
  localparam int IDX_LSB  = 4;
  localparam int IDX_MSB  = 6;
  localparam int TAG_LSB  = 7;
  localparam int TAG_MSB  = 9;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_e;

  // Word 0 lives in the low 32 bits of a block.
  function automatic logic [WORD_W-1:0] select_word(
    input logic [BLOCK_W-1:0]  blk,
    input logic [OFFSET_W-1:0] off
  );
    return blk[{off, 5'b00000} +: WORD_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_cache_if.sv
// ----------------------------------------------------------------------------
// instr_cache_if: CPU fetch port and instruction-memory block-read port.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface instr_cache_if;
  import icache_pkg::*;

  logic [31:0]         PC;
  logic [WORD_W-1:0]   INSTRUCTION;
  logic                busywait;
  logic                mem_read;
  logic [MADDR_W-1:0]  mem_address;
  logic [BLOCK_W-1:0]  mem_readdata;
  logic                mem_busywait;

  modport slave (
    input  PC, mem_readdata, mem_busywait,
    output INSTRUCTION, busywait, mem_read, mem_address
  );

  modport master (
    output PC, mem_readdata, mem_busywait,
    input  INSTRUCTION, busywait, mem_read, mem_address
  );

endinterface

`default_nettype wire

// File: rtl/icache_line_array.sv
// ----------------------------------------------------------------------------
// icache_line_array: valid/tag/data storage, async read, one sync write port.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module icache_line_array
  import icache_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic [INDEX_W-1:0]  rd_index,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [BLOCK_W-1:0]  rd_data,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [BLOCK_W-1:0]  wr_data
);

  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [TAG_W-1:0]   tag_d  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];
  logic [BLOCK_W-1:0] data_d [LINES];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_index] = 1'b1;
      tag_d[wr_index]   = wr_tag;
      data_d[wr_index]  = wr_data;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data contents are meaningless until the valid bit is set.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

`default_nettype wire

// File: rtl/instr_cache.sv
// ----------------------------------------------------------------------------
// instr_cache: 8-line direct-mapped read-only instruction cache, zero-wait hit.
// Define INSTR_CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instr_cache
  import icache_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  instr_cache_if.slave  bus
`ifdef INSTR_CACHE_STATS_EN
  ,
  output logic [15:0]   hit_count,
  output logic [15:0]   miss_count
`endif
);

  logic [TAG_W-1:0]    pc_tag;
  logic [INDEX_W-1:0]  pc_index;
  logic [OFFSET_W-1:0] pc_offset;
  logic                unused_pc_bits;

  assign pc_tag         = bus.PC[TAG_MSB:TAG_LSB];
  assign pc_index       = bus.PC[IDX_MSB:IDX_LSB];
  assign pc_offset      = bus.PC[OFF_MSB:OFF_LSB];
  assign unused_pc_bits = ^{bus.PC[31:TAG_MSB+1], bus.PC[OFF_LSB-1:0]};

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    miss_tag_q, miss_tag_d;
  logic [INDEX_W-1:0]  miss_index_q, miss_index_d;
  logic [BLOCK_W-1:0]  fill_data_q, fill_data_d;
  logic                mem_read_q, mem_read_d;
  logic [MADDR_W-1:0]  mem_address_q, mem_address_d;

  logic                line_valid;
  logic [TAG_W-1:0]    line_tag;
  logic [BLOCK_W-1:0]  line_data;
  logic                hit;

  icache_line_array u_lines (
    .CLK      (CLK),
    .RESET    (RESET),
    .rd_index (pc_index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (state_q == UPDATE),
    .wr_index (miss_index_q),
    .wr_tag   (miss_tag_q),
    .wr_data  (fill_data_q)
  );

  assign hit = line_valid && (line_tag == pc_tag);

  always_comb begin
    state_d       = state_q;
    miss_tag_d    = miss_tag_q;
    miss_index_d  = miss_index_q;
    fill_data_d   = fill_data_q;
    mem_read_d    = mem_read_q;
    mem_address_d = mem_address_q;
    case (state_q)
      IDLE: begin
        if (!hit) begin
          state_d       = MEM_READ;
          miss_tag_d    = pc_tag;
          miss_index_d  = pc_index;
          mem_read_d    = 1'b1;
          mem_address_d = {pc_tag, pc_index};
        end
      end
      MEM_READ: begin
        // Memory data is only guaranteed in the cycle busywait drops, so capture it here.
        if (!bus.mem_busywait) begin
          state_d       = UPDATE;
          fill_data_d   = bus.mem_readdata;
          mem_read_d    = 1'b0;
          mem_address_d = '0;
        end
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: begin
        state_d       = IDLE;
        mem_read_d    = 1'b0;
        mem_address_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= IDLE;
      miss_tag_q    <= '0;
      miss_index_q  <= '0;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
    end else begin
      state_q       <= state_d;
      miss_tag_q    <= miss_tag_d;
      miss_index_q  <= miss_index_d;
      mem_read_q    <= mem_read_d;
      mem_address_q <= mem_address_d;
    end
  end

  always_ff @(posedge CLK) begin
    fill_data_q <= fill_data_d;
  end

  // RESET gates the CPU-facing outputs so an empty cache does not report busy while held in reset.
  assign bus.busywait    = RESET && ((state_q != IDLE) || !hit);
  assign bus.INSTRUCTION = (RESET && (state_q == IDLE) && hit) ?
                           select_word(line_data, pc_offset) : '0;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_address = mem_address_q;

`ifdef INSTR_CACHE_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if ((state_q == IDLE) && hit && (hit_count_q != 16'hFFFF)) begin
      hit_count_d = hit_count_q + 16'd1;
    end
    if ((state_q == IDLE) && !hit && (miss_count_q != 16'hFFFF)) begin
      miss_count_d = miss_count_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_cache.sv
// ----------------------------------------------------------------------------
// tb_instr_cache: directed fetches with a latency-programmable memory model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_instr_cache;

  logic CLK = 1'b0;
  logic RESET;
  int   tests = 0;
  int   fails = 0;

  instr_cache_if bus ();

`ifdef INSTR_CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  bit          chk_stats = 1'b0;
  bit          stats_done = 1'b0;
`endif

  instr_cache dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
`ifdef INSTR_CACHE_STATS_EN
    , .hit_count  (hit_count)
    , .miss_count (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  // Memory model: mem_busywait high for (mem_lat-1) cycles of an active read.
  int mem_lat = 5;
  int mem_cnt = 0;
  always @(posedge CLK) mem_cnt <= bus.mem_read ? mem_cnt + 1 : 0;
  assign bus.mem_busywait = bus.mem_read && (mem_cnt < mem_lat - 1);

  always_comb begin
    bus.mem_readdata = '0;
    for (int w = 0; w < 4; w++) begin
      bus.mem_readdata[32*w +: 32] = {16'hC0DE, 2'b00, bus.mem_address, 6'b000000, 2'(w)};
    end
  end

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return {16'hC0DE, 2'b00, pc[9:4], 6'b000000, pc[3:2]};
  endfunction

  logic [31:0] exp_instr [64];
  int          exp_busy  [64];
  logic [5:0]  exp_addr  [64];
  int          issued = 0;
  int          addr_issued = 0;
  int          completed = 0;
  int          busy_cnt = 0;
  int          addr_seen = 0;
  logic        mr_prev = 1'b0;
  bit          final_req = 1'b0;
  bit          final_done = 1'b0;

  // Monitor / scoreboard: all comparisons happen here, on the falling edge.
  always @(negedge CLK) begin
    if (!RESET) begin
      tests++;
      if (bus.busywait !== 1'b0 || bus.INSTRUCTION !== 32'h0 ||
          bus.mem_read !== 1'b0 || bus.mem_address !== 6'h00) begin
        fails++;
        $display("FAIL reset_outputs: busywait=%b instr=%h mem_read=%b mem_address=%h, required 0/00000000/0/00",
                 bus.busywait, bus.INSTRUCTION, bus.mem_read, bus.mem_address);
      end
    end else begin
      if (bus.mem_read !== 1'b1) begin
        tests++;
        if (bus.mem_address !== 6'h00) begin
          fails++;
          $display("FAIL mem_address_idle: got %h, required 00", bus.mem_address);
        end
      end
      if (bus.mem_read === 1'b1 && !mr_prev) begin
        tests++;
        if (addr_seen >= addr_issued) begin
          fails++;
          $display("FAIL unexpected_mem_read: mem_address=%h, required no read", bus.mem_address);
        end else begin
          if (bus.mem_address !== exp_addr[addr_seen]) begin
            fails++;
            $display("FAIL mem_address: got %h, required %h", bus.mem_address, exp_addr[addr_seen]);
          end
          addr_seen++;
        end
      end
      if (issued != completed) begin
        if (bus.busywait !== 1'b0) begin
          busy_cnt++;
        end else begin
          tests += 2;
          if (bus.INSTRUCTION !== exp_instr[completed]) begin
            fails++;
            $display("FAIL instruction[%0d]: got %h, required %h", completed, bus.INSTRUCTION, exp_instr[completed]);
          end
          if (busy_cnt != exp_busy[completed]) begin
            fails++;
            $display("FAIL busy_cycles[%0d]: got %0d, required %0d", completed, busy_cnt, exp_busy[completed]);
          end
          completed++;
          busy_cnt = 0;
        end
      end
    end
    mr_prev = (bus.mem_read === 1'b1);
`ifdef INSTR_CACHE_STATS_EN
    if (chk_stats && !stats_done) begin
      tests += 2;
      if (miss_count !== 16'd3) begin
        fails++;
        $display("FAIL miss_count: got %0d, required 3", miss_count);
      end
      if (hit_count !== 16'd9) begin
        fails++;
        $display("FAIL hit_count: got %0d, required 9", hit_count);
      end
      stats_done = 1'b1;
    end
`endif
    if (final_req && !final_done) begin
      tests += 2;
      if (addr_seen != addr_issued) begin
        fails++;
        $display("FAIL mem_read_count: got %0d, required %0d", addr_seen, addr_issued);
      end
      if (completed != issued) begin
        fails++;
        $display("FAIL fetch_count: got %0d, required %0d", completed, issued);
      end
      final_done = 1'b1;
    end
  end

  // Issue one fetch; caller is positioned just after a rising edge.
  // With sw>0 the PC moves to pc2 sw edges into the fetch.
  task automatic fetch(input logic [31:0] pc, input int busy, input bit fill,
                       input logic [31:0] pc2, input int sw);
    #1;
    bus.PC = pc;
    if (fill) begin
      exp_addr[addr_issued] = pc[9:4];
      addr_issued++;
      if (sw > 0) begin
        exp_addr[addr_issued] = pc2[9:4];
        addr_issued++;
      end
    end
    exp_instr[issued] = word_of((sw > 0) ? pc2 : pc);
    exp_busy[issued]  = busy;
    issued++;
    for (int i = 0; i < 200 && issued != completed; i++) begin
      @(posedge CLK);
      if (sw > 0 && i == sw - 1) begin
        #1;
        bus.PC = pc2;
      end
    end
    if (issued != completed) begin
      $display("FAIL fetch_timeout: pc=%h still busy after 200 cycles", pc);
      $fatal(1);
    end
  endtask

  initial begin
    RESET  = 1'b0;
    bus.PC = 32'h0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b1;

    fetch(32'h000, 7, 1'b1, 32'h0, 0);
    fetch(32'h004, 0, 1'b0, 32'h0, 0);
    fetch(32'h008, 0, 1'b0, 32'h0, 0);
    fetch(32'h00C, 0, 1'b0, 32'h0, 0);
    fetch(32'h000, 0, 1'b0, 32'h0, 0);
    fetch(32'h080, 7, 1'b1, 32'h0, 0);
    fetch(32'h084, 0, 1'b0, 32'h0, 0);
    fetch(32'h000, 7, 1'b1, 32'h0, 0);

    mem_lat = 1;
    fetch(32'h3F0, 3, 1'b1, 32'h0, 0);
    mem_lat = 3;
    fetch(32'h1FC, 5, 1'b1, 32'h0, 0);
    fetch(32'h3F0, 5, 1'b1, 32'h0, 0);
    fetch(32'h3F4, 0, 1'b0, 32'h0, 0);
    mem_lat = 5;

    // Abandon a fill with reset while mem_read is high.
    #1;
    bus.PC = 32'h040;
    exp_addr[addr_issued] = 6'h04;
    addr_issued++;
    @(posedge CLK);
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1 RESET = 1'b1;

    fetch(32'h000, 7, 1'b1, 32'h0, 0);
    fetch(32'h010, 14, 1'b1, 32'h020, 2);
    fetch(32'h010, 0, 1'b0, 32'h0, 0);
    fetch(32'h024, 0, 1'b0, 32'h0, 0);
    fetch(32'h004, 0, 1'b0, 32'h0, 0);
    fetch(32'h008, 0, 1'b0, 32'h0, 0);
    fetch(32'h00C, 0, 1'b0, 32'h0, 0);
    fetch(32'h014, 0, 1'b0, 32'h0, 0);
    fetch(32'h028, 0, 1'b0, 32'h0, 0);

`ifdef INSTR_CACHE_STATS_EN
    #1 chk_stats = 1'b1;
    for (int i = 0; i < 10 && !stats_done; i++) @(posedge CLK);
`endif

    final_req = 1'b1;
    for (int i = 0; i < 10 && !final_done; i++) @(posedge CLK);
    if (!final_done) begin
      $display("FAIL final_check: monitor did not respond");
      $fatal(1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_cache.md
INSTR_CACHE -- requirements
Module: instr_cache

Interface
REQ-001 The block SHALL use one clock and one reset; reset is asynchronous and active-low.
REQ-002 The block SHALL have port CLK, input, 1 bit: rising-edge clock shared with the CPU.
REQ-003 The block SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port PC, input, 32 bits: fetch address from the CPU; only PC[9:0] is used.
REQ-005 The block SHALL have port INSTRUCTION, output, 32 bits: fetched instruction word.
REQ-006 The block SHALL have port busywait, output, 1 bit: high while the fetch is unresolved; the CPU holds PC while it is high.
REQ-007 The block SHALL have port mem_read, output, 1 bit: block-read request to instruction memory.
REQ-008 The block SHALL have port mem_address, output, 6 bits: block address {tag, index}.
REQ-009 The block SHALL have port mem_readdata, input, 128 bits: returned block; word0 is in [31:0].
REQ-010 The block SHALL have port mem_busywait, input, 1 bit: memory busy; data is valid in the cycle it falls.

Function
REQ-011 The cache SHALL be direct-mapped with 8 lines of 128 bits (4 words), 1 valid bit and a 3-bit tag per line.
REQ-012 Address decode SHALL be: word offset = PC[3:2], index = PC[6:4], tag = PC[9:7]; PC[1:0] are ignored.
REQ-013 A hit SHALL be valid[index] AND tag[index] == PC[9:7], evaluated combinationally.
REQ-014 On a hit in IDLE, INSTRUCTION SHALL present the selected word and busywait SHALL be 0 in the same cycle (zero-wait hit).
REQ-015 The FSM SHALL have the states IDLE, MEM_READ and UPDATE.
REQ-016 IDLE to MEM_READ SHALL occur on a miss.
REQ-017 On the IDLE-to-MEM_READ transition, the miss tag and index SHALL be latched.
REQ-018 During the miss cycle in IDLE, busywait SHALL already be 1.
REQ-019 In MEM_READ, mem_read SHALL be 1 and mem_address SHALL equal the latched {tag, index}.
REQ-020 The FSM SHALL remain in MEM_READ while mem_busywait is 1.
REQ-021 The FSM SHALL go from MEM_READ to UPDATE on the first edge at which mem_busywait is 0.
REQ-022 In UPDATE, the line SHALL be written with mem_readdata, the latched tag and valid=1; mem_read SHALL be 0; the FSM SHALL return to IDLE next edge.
REQ-023 busywait SHALL be 1 in MEM_READ and UPDATE, and 0 in IDLE on a hit.
REQ-024 The miss penalty SHALL be memory latency + 2 cycles.
REQ-025 A PC change during MEM_READ or UPDATE SHALL NOT alter the latched request; the fill completes for the latched address, and the new PC is then evaluated in IDLE.
REQ-026 mem_read and mem_address SHALL never be asserted in IDLE or UPDATE; mem_address SHALL be 0 when mem_read is 0.
REQ-027 No line SHALL ever be written except in UPDATE; the cache is read-only toward the CPU.

Reset
REQ-028 RESET low SHALL immediately force the state to IDLE.
REQ-029 RESET low SHALL clear all valid bits.
REQ-030 RESET low SHALL drive mem_read=0 and mem_address=0.
REQ-031 Tag and data arrays SHALL NOT require reset.
REQ-032 During reset, busywait SHALL be 0 and INSTRUCTION SHALL be 32'h0.
REQ-033 A reset asserted mid-MEM_READ SHALL abandon the fill; no line is written.

Configuration
REQ-034 The macro INSTR_CACHE_STATS_EN SHALL control the statistics feature.
REQ-035 When INSTR_CACHE_STATS_EN is defined, the block SHALL add outputs hit_count[15:0] and miss_count[15:0].
REQ-036 When INSTR_CACHE_STATS_EN is defined, hit_count SHALL increment once per completed hit fetch and miss_count once per IDLE-to-MEM_READ transition.
REQ-037 Both counters SHALL saturate at 16'hFFFF and clear on reset.
REQ-038 When INSTR_CACHE_STATS_EN is undefined, the ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-039 Package icache_pkg SHALL hold: the line count, tag, index, offset and block widths; the state encoding for IDLE, MEM_READ and UPDATE; and the address-field slice constants.
REQ-040 Sub-module icache_line_array SHALL hold the valid, tag and data storage, with a combinational read port and a single synchronous write port driven in UPDATE.

Verification
REQ-041 Reset then PC=0, memory latency 5 cycles -> busywait=1 for 7 cycles, one mem_read with mem_address=6'h00, then INSTRUCTION = mem word0.
REQ-042 Fill block 0, then PC=4, 8, 12 -> each is a zero-wait hit returning words 1-3; no mem_read.
REQ-043 PC=0x000 fill, then PC=0x080 (same index 0, tag 1) -> miss, mem_address=6'h08, line replaced; PC=0x000 again -> miss.
REQ-044 RESET low during MEM_READ -> mem_read falls immediately; after release, PC=0 misses again.
REQ-045 PC toggled 0x010 -> 0x020 during MEM_READ -> fill completes to index 1; then index 2 misses.
REQ-046 With INSTR_CACHE_STATS_EN defined, 3 misses + 9 hits -> miss_count=3, hit_count=9.
